// File: rtl/scr1_tapc_sync.sv
// JTAG TAP controller, fully synchronous to TCK (clk).
// Runs the 1149.1 state machine and holds the IR, BYPASS and IDCODE registers.
// Decodes the RISC-V DTM instructions (DTMCS, DMI) into chain strobes for the DMI block.
// Muxes the DTM chain tdo onto the external tdo.
module scr1_tapc_sync #(
  parameter int          IR_WIDTH     = 5,
  parameter logic [31:0] IDCODE_VALUE = 32'hDEB11001,
  parameter int          CH_ID_WIDTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tms,
  input  logic                   tdi,
  output logic                   tdo,
  output logic                   tdo_en,
  output logic                   dtm_ch_sel,
  output logic [CH_ID_WIDTH-1:0] dtm_ch_id,
  output logic                   dtm_ch_capture,
  output logic                   dtm_ch_shift,
  output logic                   dtm_ch_update,
  output logic                   dtm_ch_tdi,
  input  logic                   dtm_ch_tdo
);

  // TAP states
  localparam logic [3:0] TLR    = 4'd0;
  localparam logic [3:0] RTI    = 4'd1;
  localparam logic [3:0] SEL_DR = 4'd2;
  localparam logic [3:0] CAP_DR = 4'd3;
  localparam logic [3:0] SH_DR  = 4'd4;
  localparam logic [3:0] EX1_DR = 4'd5;
  localparam logic [3:0] PAU_DR = 4'd6;
  localparam logic [3:0] EX2_DR = 4'd7;
  localparam logic [3:0] UPD_DR = 4'd8;
  localparam logic [3:0] SEL_IR = 4'd9;
  localparam logic [3:0] CAP_IR = 4'd10;
  localparam logic [3:0] SH_IR  = 4'd11;
  localparam logic [3:0] EX1_IR = 4'd12;
  localparam logic [3:0] PAU_IR = 4'd13;
  localparam logic [3:0] EX2_IR = 4'd14;
  localparam logic [3:0] UPD_IR = 4'd15;

  // Instruction codes
  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'('h01);
  localparam logic [IR_WIDTH-1:0] IR_DTMCS  = IR_WIDTH'('h10);
  localparam logic [IR_WIDTH-1:0] IR_DMI    = IR_WIDTH'('h11);

  logic [3:0]          state;
  logic [3:0]          state_next;
  logic [IR_WIDTH-1:0] ir;
  logic [IR_WIDTH-1:0] ir_shift;
  logic                bypass;
  logic [31:0]         idcode_shift;

  logic is_idcode;
  logic is_dtmcs;
  logic is_dmi;

  assign is_idcode = (ir == IR_IDCODE);
  assign is_dtmcs  = (ir == IR_DTMCS);
  assign is_dmi    = (ir == IR_DMI);

  // Standard 1149.1 next-state function on tms
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      TLR:    state_next = tms ? TLR    : RTI;
      RTI:    state_next = tms ? SEL_DR : RTI;
      SEL_DR: state_next = tms ? SEL_IR : CAP_DR;
      CAP_DR: state_next = tms ? EX1_DR : SH_DR;
      SH_DR:  state_next = tms ? EX1_DR : SH_DR;
      EX1_DR: state_next = tms ? UPD_DR : PAU_DR;
      PAU_DR: state_next = tms ? EX2_DR : PAU_DR;
      EX2_DR: state_next = tms ? UPD_DR : SH_DR;
      UPD_DR: state_next = tms ? SEL_DR : RTI;
      SEL_IR: state_next = tms ? TLR    : CAP_IR;
      CAP_IR: state_next = tms ? EX1_IR : SH_IR;
      SH_IR:  state_next = tms ? EX1_IR : SH_IR;
      EX1_IR: state_next = tms ? UPD_IR : PAU_IR;
      PAU_IR: state_next = tms ? EX2_IR : PAU_IR;
      EX2_IR: state_next = tms ? UPD_IR : SH_IR;
      UPD_IR: state_next = tms ? SEL_DR : RTI;
      default: state_next = TLR;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) state <= TLR;
    else     state <= state_next;
  end

  // Instruction register path; TLR holds IR at IDCODE for as long as it is occupied
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_shift <= '0;
      ir       <= IR_IDCODE;
    end else begin
      if (state == CAP_IR)     ir_shift <= IR_WIDTH'(1);
      else if (state == SH_IR) ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};

      if (state == TLR)         ir <= IR_IDCODE;
      else if (state == UPD_IR) ir <= ir_shift;
    end
  end

  // Internal data registers; only the IR-selected one captures or shifts
  always_ff @(posedge clk) begin
    if (rst) begin
      bypass       <= 1'b0;
      idcode_shift <= IDCODE_VALUE;
    end else if (is_idcode) begin
      if (state == CAP_DR)     idcode_shift <= IDCODE_VALUE;
      else if (state == SH_DR) idcode_shift <= {tdi, idcode_shift[31:1]};
    end else if (!is_dtmcs && !is_dmi) begin
      if (state == CAP_DR)     bypass <= 1'b0;
      else if (state == SH_DR) bypass <= tdi;
    end
  end

  // Chain select follows IR, so it only moves on UPD_IR exit or reset/TLR
  always_comb begin
    dtm_ch_sel = is_dtmcs | is_dmi;
    dtm_ch_id  = '0;
    if (is_dtmcs)    dtm_ch_id = CH_ID_WIDTH'(1);
    else if (is_dmi) dtm_ch_id = CH_ID_WIDTH'(2);
  end

  assign dtm_ch_capture = (state == CAP_DR) & dtm_ch_sel;
  assign dtm_ch_shift   = (state == SH_DR)  & dtm_ch_sel;
  assign dtm_ch_update  = (state == UPD_DR) & dtm_ch_sel;
  assign dtm_ch_tdi     = tdi;
  assign tdo_en         = (state == SH_IR) | (state == SH_DR);

  // tdo mux, purely from registered values so it settles well before the next edge
  always_comb begin
    tdo = 1'b0;
    if (state == SH_IR) begin
      tdo = ir_shift[0];
    end else if (state == SH_DR) begin
      if (dtm_ch_sel)     tdo = dtm_ch_tdo;
      else if (is_idcode) tdo = idcode_shift[0];
      else                tdo = bypass;
    end
  end

endmodule

// File: tb/tb_scr1_tapc_sync.sv
// Directed bench for scr1_tapc_sync: expected tdo bits go into a scoreboard
// queue as stimulus is driven and are popped as the TAP shifts them out.
module tb_scr1_tapc_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic       tms;
  logic       tdi;
  logic       tdo;
  logic       tdo_en;
  logic       dtm_ch_sel;
  logic [1:0] dtm_ch_id;
  logic       dtm_ch_capture;
  logic       dtm_ch_shift;
  logic       dtm_ch_update;
  logic       dtm_ch_tdi;
  logic       dtm_ch_tdo;

  scr1_tapc_sync dut (
    .clk            (clk),
    .rst            (rst),
    .tms            (tms),
    .tdi            (tdi),
    .tdo            (tdo),
    .tdo_en         (tdo_en),
    .dtm_ch_sel     (dtm_ch_sel),
    .dtm_ch_id      (dtm_ch_id),
    .dtm_ch_capture (dtm_ch_capture),
    .dtm_ch_shift   (dtm_ch_shift),
    .dtm_ch_update  (dtm_ch_update),
    .dtm_ch_tdi     (dtm_ch_tdi),
    .dtm_ch_tdo     (dtm_ch_tdo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    logic  exp;
  } sb_t;

  sb_t sb_q[$];

  int total = 0;
  int bad   = 0;

  // Per-scan observation counters, sampled on the falling edge
  int         n_cap, n_sh, n_upd, n_en, n_chan_bad;
  logic [2:0] exp_chan;  // expected {dtm_ch_sel, dtm_ch_id}

  localparam logic [31:0] IDCODE = 32'hDEB11001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    n_cap = 0; n_sh = 0; n_upd = 0; n_en = 0; n_chan_bad = 0;
  endtask

  task automatic push(input string tag, input logic exp);
    sb_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  // One TCK cycle: drive, observe the current state on the falling edge, then advance.
  task automatic cyc(input logic m, input logic d, input bit pop);
    sb_t it;
    tms = m;
    tdi = d;
    @(negedge clk);
    if (dtm_ch_capture) n_cap++;
    if (dtm_ch_shift)   n_sh++;
    if (dtm_ch_update)  n_upd++;
    if (tdo_en)         n_en++;
    if ({dtm_ch_sel, dtm_ch_id} !== exp_chan) n_chan_bad++;
    if (pop) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        it = sb_q.pop_front();
        check(it.tag, 32'(tdo), 32'(it.exp));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // From RTI: load an IR value, expecting the captured 00001 pattern on tdo; ends in RTI.
  task automatic ir_scan(input logic [4:0] v);
    cyc(1'b1, 1'b0, 1'b0);  // -> SEL_DR
    cyc(1'b1, 1'b0, 1'b0);  // -> SEL_IR
    cyc(1'b0, 1'b0, 1'b0);  // -> CAP_IR
    cyc(1'b0, 1'b0, 1'b0);  // -> SH_IR
    for (int i = 0; i < 5; i++) push("ir_tdo", (i == 0));
    for (int i = 0; i < 5; i++) cyc((i == 4), v[i], 1'b1);  // last -> EX1_IR
    cyc(1'b1, 1'b0, 1'b0);  // -> UPD_IR
    cyc(1'b0, 1'b0, 1'b0);  // -> RTI, new IR in effect
    check("ir_sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    logic b;
    rst = 1'b1; tms = 1'b1; tdi = 1'b1; dtm_ch_tdo = 1'b0;
    exp_chan = 3'b000;
    clr_counts();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_state",  32'(dut.state), 32'd0);
    check("rst_ir",     32'(dut.ir), 32'h01);
    check("rst_idcode", dut.idcode_shift, IDCODE);
    check("rst_bypass", 32'(dut.bypass), 32'd0);
    check("rst_outs", 32'({tdo, tdo_en, dtm_ch_sel, dtm_ch_id, dtm_ch_capture,
                           dtm_ch_shift, dtm_ch_update}), 32'd0);
    check("rst_ch_tdi_1", 32'(dtm_ch_tdi), 32'd1);
    tdi = 1'b0; #1;
    check("rst_ch_tdi_0", 32'(dtm_ch_tdi), 32'd0);
    rst = 1'b0;

    // IDCODE scan straight after reset
    cyc(1'b0, 1'b0, 1'b0);  // -> RTI
    cyc(1'b1, 1'b0, 1'b0);  // -> SEL_DR
    cyc(1'b0, 1'b0, 1'b0);  // -> CAP_DR
    cyc(1'b0, 1'b0, 1'b0);  // -> SH_DR
    clr_counts();
    for (int i = 0; i < 32; i++) push("idcode_tdo", IDCODE[i]);
    for (int i = 0; i < 32; i++) cyc((i == 31), 1'b0, 1'b1);
    check("idcode_sb_empty", 32'(sb_q.size()), 32'd0);
    check("idcode_sel_stable", 32'(n_chan_bad), 32'd0);
    check("idcode_en_cycles", 32'(n_en), 32'd32);

    // Mid-scan escape to TLR with five tms=1 edges
    cyc(1'b1, 1'b0, 1'b0);  // EX1 -> UPD
    cyc(1'b1, 1'b0, 1'b0);  // -> SEL_DR
    cyc(1'b0, 1'b0, 1'b0);  // -> CAP_DR
    cyc(1'b0, 1'b0, 1'b0);  // -> SH_DR
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (i >= 1) check("tlr_tdo_en", 32'(tdo_en), 32'd0);
    end
    check("tlr_state", 32'(dut.state), 32'd0);
    check("tlr_ir", 32'(dut.ir), 32'h01);

    // IR = DMI
    cyc(1'b0, 1'b0, 1'b0);  // -> RTI
    clr_counts();
    ir_scan(5'h11);
    check("dmi_sel_id", 32'({dtm_ch_sel, dtm_ch_id}), 32'b110);
    check("dmi_no_early_sel", 32'(n_chan_bad), 32'd0);

    // DMI DR scan: 20 shifts, 3-cycle pause, 21 shifts
    exp_chan = 3'b110;
    clr_counts();
    cyc(1'b1, 1'b0, 1'b0);  // -> SEL_DR
    cyc(1'b0, 1'b0, 1'b0);  // -> CAP_DR
    cyc(1'b0, 1'b0, 1'b0);  // -> SH_DR
    for (int i = 0; i < 20; i++) begin
      b = 1'($urandom_range(0, 1));
      dtm_ch_tdo = b;
      push("dmi_tdo", b);
      cyc((i == 19), 1'($urandom_range(0, 1)), 1'b1);
    end
    cyc(1'b0, 1'b0, 1'b0);  // EX1 -> PAU
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);  // PAU -> EX2 (three PAU cycles)
    check("dmi_pause_shift", 32'(n_sh), 32'd20);
    cyc(1'b0, 1'b0, 1'b0);  // EX2 -> SH_DR
    for (int i = 0; i < 21; i++) begin
      b = 1'($urandom_range(0, 1));
      dtm_ch_tdo = b;
      push("dmi_tdo", b);
      cyc((i == 20), 1'($urandom_range(0, 1)), 1'b1);
    end
    cyc(1'b1, 1'b0, 1'b0);  // EX1 -> UPD
    cyc(1'b0, 1'b0, 1'b0);  // UPD -> RTI
    cyc(1'b0, 1'b0, 1'b0);
    check("dmi_cap", 32'(n_cap), 32'd1);
    check("dmi_shift", 32'(n_sh), 32'd41);
    check("dmi_upd", 32'(n_upd), 32'd1);
    check("dmi_en", 32'(n_en), 32'd41);
    check("dmi_chan_stable", 32'(n_chan_bad), 32'd0);
    check("dmi_sb_empty", 32'(sb_q.size()), 32'd0);

    // BYPASS via 5'h1F
    clr_counts();
    ir_scan(5'h1F);
    exp_chan = 3'b000;
    check("byp_sel_id", 32'({dtm_ch_sel, dtm_ch_id}), 32'd0);
    clr_counts();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);  // -> SH_DR
    push("byp_tdo", 1'b0); push("byp_tdo", 1'b1);
    push("byp_tdo", 1'b0); push("byp_tdo", 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);  // -> UPD_DR
    cyc(1'b0, 1'b0, 1'b0);  // -> RTI
    check("byp_sb_empty", 32'(sb_q.size()), 32'd0);
    check("byp_strobes", 32'(n_cap + n_sh + n_upd), 32'd0);
    check("byp_chan", 32'(n_chan_bad), 32'd0);

    // DTMCS, then reset mid-shift
    ir_scan(5'h10);
    check("dtmcs_sel_id", 32'({dtm_ch_sel, dtm_ch_id}), 32'b101);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);  // -> SH_DR
    check("dtmcs_shift_on", 32'(dtm_ch_shift), 32'd1);
    rst = 1'b1;
    exp_chan = 3'b101;
    cyc(1'b0, 1'b1, 1'b0);
    check("rst_mid_strobes", 32'({dtm_ch_capture, dtm_ch_shift, dtm_ch_update}), 32'd0);
    check("rst_mid_id", 32'({dtm_ch_sel, dtm_ch_id}), 32'd0);
    check("rst_mid_ir", 32'(dut.ir), 32'h01);
    check("rst_mid_state", 32'(dut.state), 32'd0);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
